// File: rtl/sdes_keymix.sv
// S-DES subkey schedule plus E/P and round-key mix feeding S0/S1.
// Optional zeroize input enabled by defining SDES_KEY_ZEROIZE_EN.
module sdes_keymix #(
    parameter bit SWAP_DECRYPT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef SDES_KEY_ZEROIZE_EN
    input  logic       key_clear,
`endif
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [0:9] key_in,
    input  logic       decrypt,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [0:3] in_r,
    input  logic       in_round,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [0:3] s0_in,
    output logic [0:3] s1_in
);

    typedef enum logic [1:0] {IDLE, GEN1, GEN2, KEYS_OK} state_t;

    function automatic logic [0:9] p10(input logic [0:9] k);
        return {k[2], k[4], k[1], k[6], k[3], k[9], k[0], k[8], k[7], k[5]};
    endfunction

    function automatic logic [0:7] p8(input logic [0:9] k);
        return {k[5], k[2], k[6], k[3], k[7], k[4], k[9], k[8]};
    endfunction

    function automatic logic [0:9] ls1(input logic [0:9] k);
        return {k[1:4], k[0], k[6:9], k[5]};
    endfunction

    function automatic logic [0:9] ls2(input logic [0:9] k);
        return {k[2:4], k[0:1], k[7:9], k[5:6]};
    endfunction

    function automatic logic [0:7] ep(input logic [0:3] r);
        return {r[3], r[0], r[1], r[2], r[1], r[2], r[3], r[0]};
    endfunction

    state_t     state_q, state_d;
    logic [0:9] key_q, key_d;
    logic [0:9] t_q, t_d;
    logic [0:7] k1_q, k1_d;
    logic [0:7] k2_q, k2_d;
    logic       dec_q, dec_d;
    logic       out_valid_q, out_valid_d;
    logic [0:7] s_q, s_d;

    logic       key_acc;
    logic       in_acc;
    logic       sel;
    logic [0:7] mix;

    assign key_ready = (state_q == IDLE) |
                       ((state_q == KEYS_OK) & ~out_valid_q);
    assign in_ready  = (state_q == KEYS_OK) & (~out_valid_q | out_ready);
    assign key_acc   = key_valid & key_ready;
    assign in_acc    = in_valid & in_ready;

    // Decrypt runs the rounds with the subkeys in reverse order.
    assign sel = in_round ^ (dec_q & SWAP_DECRYPT);
    assign mix = ep(in_r) ^ (sel ? k2_q : k1_q);

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        t_d         = t_q;
        k1_d        = k1_q;
        k2_d        = k2_q;
        dec_d       = dec_q;
        out_valid_d = out_valid_q;
        s_d         = s_q;

        if (in_acc) begin
            s_d         = mix;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE, KEYS_OK: begin
                if (key_acc) begin
                    key_d   = key_in;
                    dec_d   = decrypt;
                    state_d = GEN1;
                end
            end
            GEN1: begin
                t_d     = ls1(p10(key_q));
                k1_d    = p8(t_d);
                state_d = GEN2;
            end
            GEN2: begin
                k2_d    = p8(ls2(t_q));
                state_d = KEYS_OK;
            end
        endcase

`ifdef SDES_KEY_ZEROIZE_EN
        if (key_clear) begin
            state_d     = IDLE;
            key_d       = '0;
            t_d         = '0;
            k1_d        = '0;
            k2_d        = '0;
            dec_d       = 1'b0;
            out_valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            key_q       <= '0;
            t_q         <= '0;
            k1_q        <= '0;
            k2_q        <= '0;
            dec_q       <= 1'b0;
            out_valid_q <= 1'b0;
            s_q         <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            t_q         <= t_d;
            k1_q        <= k1_d;
            k2_q        <= k2_d;
            dec_q       <= dec_d;
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
        end
    end

    assign out_valid = out_valid_q;
    assign s0_in     = s_q[0:3];
    assign s1_in     = s_q[4:7];

endmodule

// File: tb/tb_sdes_keymix.sv
// Directed + randomized bench for sdes_keymix with a scoreboard queue.
// Covers the optional zeroize input when SDES_KEY_ZEROIZE_EN is defined.
module tb_sdes_keymix;

    localparam bit SWAP = 1'b1;
    localparam int P10T [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    localparam int P8T  [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
    localparam int EPT  [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_valid;
    logic       key_ready;
    logic [0:9] key_in;
    logic       decrypt;
    logic       in_valid;
    logic       in_ready;
    logic [0:3] in_r;
    logic       in_round;
    logic       out_valid;
    logic       out_ready;
    logic [0:3] s0_in;
    logic [0:3] s1_in;
    logic       kc;

    int n_cmp = 0;
    int n_bad = 0;
    logic [0:7] sb[$];
    logic [0:7] mk1 = '0;
    logic [0:7] mk2 = '0;
    logic       mdec = 1'b0;

`ifdef SDES_KEY_ZEROIZE_EN
    logic key_clear;
    assign kc = key_clear;
`else
    assign kc = 1'b0;
`endif

    sdes_keymix #(.SWAP_DECRYPT(SWAP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef SDES_KEY_ZEROIZE_EN
        .key_clear (key_clear),
`endif
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
        .decrypt   (decrypt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_round  (in_round),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s0_in     (s0_in),
        .s1_in     (s1_in)
    );

    always #5 clk = ~clk;

    function automatic logic [0:9] m_p10(input logic [0:9] k);
        logic [0:9] o;
        for (int i = 0; i < 10; i++) o[i] = k[P10T[i]-1];
        return o;
    endfunction

    function automatic logic [0:7] m_p8(input logic [0:9] k);
        logic [0:7] o;
        for (int i = 0; i < 8; i++) o[i] = k[P8T[i]-1];
        return o;
    endfunction

    function automatic logic [0:9] m_rot(input logic [0:9] k, input int n);
        logic [0:9] o;
        for (int i = 0; i < 5; i++) begin
            o[i]   = k[(i+n)%5];
            o[i+5] = k[5+(i+n)%5];
        end
        return o;
    endfunction

    function automatic logic [0:7] exp_mix(input logic [0:3] r, input logic rnd);
        logic [0:7] e;
        logic       s;
        for (int i = 0; i < 8; i++) e[i] = r[EPT[i]-1];
        s = rnd ^ (mdec & SWAP);
        return e ^ (s ? mk2 : mk1);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [0:9] k, input logic d);
        key_in = k;
        decrypt = d;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        tick();
        tick();
    endtask

    // Monitor: handshakes are decided by values stable at the negedge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (kc) begin
                mk1 = '0;
                mk2 = '0;
                mdec = 1'b0;
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    n_cmp++;
                    assert (sb.size() > 0) else begin
                        n_bad++;
                        $error("FAIL sb_empty observed=%h expected=queued", {s0_in, s1_in});
                    end
                    if (sb.size() > 0) check("sb_out", {s0_in, s1_in}, sb.pop_front());
                end
                if (in_valid && in_ready) sb.push_back(exp_mix(in_r, in_round));
                if (key_valid && key_ready) begin
                    logic [0:9] t;
                    t = m_rot(m_p10(key_in), 1);
                    mk1 = m_p8(t);
                    mk2 = m_p8(m_rot(t, 2));
                    mdec = decrypt;
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        key_valid = 1'b0;
        key_in = '0;
        decrypt = 1'b0;
        in_valid = 1'b0;
        in_r = '0;
        in_round = 1'b0;
        out_ready = 1'b1;
`ifdef SDES_KEY_ZEROIZE_EN
        key_clear = 1'b0;
`endif
        #2;
        check("rst_key_ready", key_ready, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_s", {s0_in, s1_in}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        key_in = 10'b1010000010;
        decrypt = 1'b0;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        check("gen1_key_ready", key_ready, 0);
        check("gen1_in_ready", in_ready, 0);
        tick();
        check("gen2_key_ready", key_ready, 0);
        check("gen2_in_ready", in_ready, 0);
        tick();
        check("ok_in_ready", in_ready, 1);
        check("ok_key_ready", key_ready, 1);

        in_r = 4'b1010;
        in_round = 1'b0;
        in_valid = 1'b1;
        tick();
        check("enc_r0", {out_valid, s0_in, s1_in}, {1'b1, 8'b11110001});
        in_round = 1'b1;
        tick();
        check("enc_r1", {out_valid, s0_in, s1_in}, {1'b1, 8'b00010110});
        in_valid = 1'b0;
        tick();
        check("drained", out_valid, 0);

        load_key(10'b1010000010, 1'b1);
        check("dec_in_ready", in_ready, 1);
        in_r = 4'b1010;
        in_round = 1'b0;
        in_valid = 1'b1;
        tick();
        check("dec_r0", {out_valid, s0_in, s1_in}, {1'b1, 8'b00010110});

        out_ready = 1'b0;
        in_r = 4'b0110;
        in_round = 1'b1;
        key_in = 10'b0111010011;
        decrypt = 1'b0;
        key_valid = 1'b1;
        #1;
        check("bp_key_ready", key_ready, 0);
        check("bp_in_ready", in_ready, 0);
        repeat (2) begin
            tick();
            check("bp_hold", {out_valid, s0_in, s1_in}, {1'b1, 8'b00010110});
            check("bp_readies", {key_ready, in_ready}, 0);
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        tick();
        check("bp_drain_ov", out_valid, 0);
        check("bp_drain_key_ready", key_ready, 1);
        tick();
        key_valid = 1'b0;
        check("bp_key_taken", key_ready, 0);
        tick();

        #2;
        rst_n = 1'b0;
        #1;
        check("rst_gen2", {out_valid, key_ready, in_ready}, 3'b010);
        sb.delete();
        mk1 = '0;
        mk2 = '0;
        mdec = 1'b0;
        tick();
        rst_n = 1'b1;
        check("post_rst_in_ready", in_ready, 0);

        load_key(10'b0111010011, 1'b0);
        check("k2_in_ready", in_ready, 1);
        in_r = 4'b1100;
        in_round = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("pend", {out_valid, s0_in, s1_in}, {1'b1, exp_mix(4'b1100, 1'b0)});
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_pend", {out_valid, s0_in, s1_in}, 0);
        sb.delete();
        mk1 = '0;
        mk2 = '0;
        mdec = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;

        load_key(10'b1100011110, 1'b1);
        for (int i = 0; i < 60; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_r = 4'($urandom);
            in_round = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("sb_end_empty", 16'(sb.size()), 0);

`ifdef SDES_KEY_ZEROIZE_EN
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        check("clr_in_ready", in_ready, 0);
        check("clr_key_ready", key_ready, 1);
        load_key(10'b1010000010, 1'b0);
        in_r = 4'b1010;
        in_round = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("clr_reload", {out_valid, s0_in, s1_in}, {1'b1, 8'b11110001});
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
